// File: rtl/serial_shift_unit_pkg.sv
// Shared encodings for the serial shift unit: operation codes and FSM states.
package serial_shift_unit_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_shift_unit_if.sv
// Request/response bundle between the execution path and the serial shifter.
interface serial_shift_unit_if #(
  parameter int size = 32,
  parameter int shw  = 5
);

  logic            start_i;
  logic [1:0]      op_i;
  logic [shw-1:0]  shamt_i;
  logic [size-1:0] data_i;
  logic            busy_o;
  logic            done_o;
  logic [size-1:0] data_o;

  // Requester side: issues shifts, watches the handshake and result.
  modport master (
    output start_i, op_i, shamt_i, data_i,
    input  busy_o, done_o, data_o
  );

  // Shifter side.
  modport slave (
    input  start_i, op_i, shamt_i, data_i,
    output busy_o, done_o, data_o
  );

endinterface

// File: rtl/serial_shift_unit_shift_step.sv
// One-position shift of a data word for the selected operation; purely combinational.
module shift_step
  import serial_shift_unit_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [size-1:0] data,
  input  op_e             op,
  output logic [size-1:0] result
);

  logic signed [size-1:0] data_s;

  assign data_s = $signed(data);

  // Select the single-bit shift for this op; fill bit depends on the op.
  always_comb begin
    result = data;
    case (op)
      OP_SLL:  result = {data[size-2:0], 1'b0};
      OP_SRL:  result = {1'b0, data[size-1:1]};
      OP_SRA:  result = $unsigned(data_s >>> 1);
      OP_ROTR: result = {data[0], data[size-1:1]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle variable shifter: one bit position per clock, start/busy/done handshake.
// The result register is shifted in place, so wide shifts cost cycles, not logic.
module serial_shift_unit
  import serial_shift_unit_pkg::*;
#(
  parameter int size = 32,
  parameter int shw  = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  serial_shift_unit_if.slave  bus
);

  state_e          state;
  op_e             op_q;
  logic [shw-1:0]  count;
  logic [size-1:0] data_q;
  logic [size-1:0] data_step;
  logic            ready;

  // A new request may be taken whenever no shift is in progress, including the DONE cycle.
  assign ready = (state == S_IDLE) || (state == S_DONE);

  shift_step #(
    .size (size)
  ) u_step (
    .data   (data_q),
    .op     (op_q),
    .result (data_step)
  );

  // FSM, remaining-shift counter and result register; reset abandons any shift in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      op_q   <= OP_SLL;
      count  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            data_q <= bus.data_i;
            op_q   <= op_e'(bus.op_i);
            count  <= bus.shamt_i;
            state  <= (bus.shamt_i != '0) ? S_SHIFT : S_DONE;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          data_q <= data_step;
          count  <= count - shw'(1);
          if (count == shw'(1)) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = (state == S_SHIFT);
  assign bus.done_o = (state == S_DONE);
  assign bus.data_o = data_q;

  logic unused_ok;
  assign unused_ok = ready;

endmodule
